// File: rtl/pkt_rsel_rr_if.sv
// pkt_rsel_rr_if: bundles the packet selector's input-side and output-side
// handshake/bus signals.
//   slave  modport : the selector itself (consumes packets, drives result)
//   master modport : the surrounding logic (sources + downstream sink)
// Signals:
//   node/gen/opr0/opr1/mem_wen_i_prs : packed per-channel packet fields
//   valid_i_prs / ready_o_prs        : per-channel input handshake
//   mode_i_prs, sel_i_prs            : round-robin / forced-select control
//   *_o_prs, ch_o_prs                : held output packet and its source channel
//   valid_o_prs / ready_i_prs        : output handshake
interface pkt_rsel_rr_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned NODE_W = 16,
  parameter int unsigned GEN_W  = 12,
  parameter int unsigned OPR_W  = 32,
  parameter int unsigned WEN_W  = 2
);
  logic [NCH*NODE_W-1:0] node_i_prs;
  logic [NCH*GEN_W-1:0]  gen_i_prs;
  logic [NCH*OPR_W-1:0]  opr0_i_prs;
  logic [NCH*OPR_W-1:0]  opr1_i_prs;
  logic [NCH*WEN_W-1:0]  mem_wen_i_prs;
  logic [NCH-1:0]        valid_i_prs;
  logic [NCH-1:0]        ready_o_prs;
  logic                  mode_i_prs;
  logic [CH_W-1:0]       sel_i_prs;
  logic [NODE_W-1:0]     node_o_prs;
  logic [GEN_W-1:0]      gen_o_prs;
  logic [OPR_W-1:0]      opr0_o_prs;
  logic [OPR_W-1:0]      opr1_o_prs;
  logic [WEN_W-1:0]      mem_wen_o_prs;
  logic [CH_W-1:0]       ch_o_prs;
  logic                  valid_o_prs;
  logic                  ready_i_prs;

  modport slave (
    input  node_i_prs, gen_i_prs, opr0_i_prs, opr1_i_prs, mem_wen_i_prs,
    input  valid_i_prs, mode_i_prs, sel_i_prs, ready_i_prs,
    output ready_o_prs, node_o_prs, gen_o_prs, opr0_o_prs, opr1_o_prs,
    output mem_wen_o_prs, ch_o_prs, valid_o_prs
  );

  modport master (
    output node_i_prs, gen_i_prs, opr0_i_prs, opr1_i_prs, mem_wen_i_prs,
    output valid_i_prs, mode_i_prs, sel_i_prs, ready_i_prs,
    input  ready_o_prs, node_o_prs, gen_o_prs, opr0_o_prs, opr1_o_prs,
    input  mem_wen_o_prs, ch_o_prs, valid_o_prs
  );
endinterface

// File: rtl/pkt_rsel_rr.sv
// pkt_rsel_rr: registered NCH-channel result-packet selector.
// Arbitrates packet sources (node, gen, opr0, opr1, mem_wen) onto a single
// output register using round-robin or forced channel selection, with
// valid/ready handshakes on both sides and one packet per cycle throughput.
// Ports:
//   clk_i_prs  : clock
//   rst_i_prs  : asynchronous active-high reset
//   bus        : pkt_rsel_rr_if.slave (packet inputs, per-channel ready,
//                mode/sel control, registered output packet + handshake)
// Optional feature (macro PRS_PKT_CNT_EN):
//   clr_i_prs  : synchronous clear of the transfer counter (beats increment)
//   cnt_o_prs  : saturating 16-bit count of output transfers
module pkt_rsel_rr #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned NODE_W = 16,
  parameter int unsigned GEN_W  = 12,
  parameter int unsigned OPR_W  = 32,
  parameter int unsigned WEN_W  = 2
) (
  input  logic          clk_i_prs,
  input  logic          rst_i_prs,
`ifdef PRS_PKT_CNT_EN
  input  logic          clr_i_prs,
  output logic [15:0]   cnt_o_prs,
`endif
  pkt_rsel_rr_if.slave  bus
);

  localparam int unsigned CNT_W = 16;

  // Output register and round-robin pointer
  logic              valid_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ptr_q;
  logic [NODE_W-1:0] node_q;
  logic [GEN_W-1:0]  gen_q;
  logic [OPR_W-1:0]  opr0_q;
  logic [OPR_W-1:0]  opr1_q;
  logic [WEN_W-1:0]  wen_q;

  // Combinational grant / handshake terms
  logic              gnt_any_c;
  logic [CH_W-1:0]   gnt_idx_c;
  logic [CH_W-1:0]   ptr_nxt_c;
  logic [CH_W-1:0]   hi_idx_c;
  logic [CH_W-1:0]   lo_idx_c;
  logic              hi_hit_c;
  logic              lo_hit_c;
  logic              load_c;
  logic              xfer_in_c;
  logic              xfer_out_c;
  logic [NCH-1:0]    ready_c;
  logic [NODE_W-1:0] node_c;
  logic [GEN_W-1:0]  gen_c;
  logic [OPR_W-1:0]  opr0_c;
  logic [OPR_W-1:0]  opr1_c;
  logic [WEN_W-1:0]  wen_c;

  // Grant selection. Round-robin keeps two candidates: the lowest valid
  // channel at or above ptr (preferred), and the lowest valid channel
  // overall (the wrap-around case). Loops run downward so the lowest wins.
  always_comb begin : grant
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    hi_hit_c  = 1'b0;
    hi_idx_c  = '0;
    lo_hit_c  = 1'b0;
    lo_idx_c  = '0;
    if (bus.mode_i_prs) begin
      // Forced: only the selected channel, and only if valid; an index
      // outside 0..NCH-1 never matches.
      for (int k = 0; k < int'(NCH); k++) begin
        if (bus.valid_i_prs[k] && (bus.sel_i_prs == CH_W'(k))) begin
          gnt_any_c = 1'b1;
          gnt_idx_c = CH_W'(k);
        end
      end
    end else begin
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
        if (bus.valid_i_prs[k]) begin
          lo_hit_c = 1'b1;
          lo_idx_c = CH_W'(k);
          if (k >= int'(ptr_q)) begin
            hi_hit_c = 1'b1;
            hi_idx_c = CH_W'(k);
          end
        end
      end
      gnt_any_c = lo_hit_c;
      gnt_idx_c = hi_hit_c ? hi_idx_c : lo_idx_c;
    end
  end

  // Handshake terms; ready is suppressed while reset is held
  always_comb begin : handshake
    load_c     = !valid_q || bus.ready_i_prs;
    xfer_out_c = valid_q && bus.ready_i_prs;
    ready_c    = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      ready_c[k] = !rst_i_prs && load_c && gnt_any_c && (gnt_idx_c == CH_W'(k));
    end
    // A grant implies the channel's valid bit, so any ready is a transfer
    xfer_in_c  = |ready_c;
    ptr_nxt_c  = (gnt_idx_c == CH_W'(NCH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
  end

  // Field mux for the granted channel
  always_comb begin : field_mux
    node_c = '0;
    gen_c  = '0;
    opr0_c = '0;
    opr1_c = '0;
    wen_c  = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (gnt_idx_c == CH_W'(k)) begin
        node_c = bus.node_i_prs[k*NODE_W +: NODE_W];
        gen_c  = bus.gen_i_prs[k*GEN_W +: GEN_W];
        opr0_c = bus.opr0_i_prs[k*OPR_W +: OPR_W];
        opr1_c = bus.opr1_i_prs[k*OPR_W +: OPR_W];
        wen_c  = bus.mem_wen_i_prs[k*WEN_W +: WEN_W];
      end
    end
  end

  // Output register: replace on input transfer, otherwise drain on output
  // transfer (data held), otherwise hold.
  always_ff @(posedge clk_i_prs or posedge rst_i_prs) begin : out_reg
    if (rst_i_prs) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
      node_q  <= '0;
      gen_q   <= '0;
      opr0_q  <= '0;
      opr1_q  <= '0;
      wen_q   <= '0;
    end else if (xfer_in_c) begin
      valid_q <= 1'b1;
      ch_q    <= gnt_idx_c;
      ptr_q   <= ptr_nxt_c;
      node_q  <= node_c;
      gen_q   <= gen_c;
      opr0_q  <= opr0_c;
      opr1_q  <= opr1_c;
      wen_q   <= wen_c;
    end else if (xfer_out_c) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_o_prs   = ready_c;
  assign bus.valid_o_prs   = valid_q;
  assign bus.ch_o_prs      = ch_q;
  assign bus.node_o_prs    = node_q;
  assign bus.gen_o_prs     = gen_q;
  assign bus.opr0_o_prs    = opr0_q;
  assign bus.opr1_o_prs    = opr1_q;
  assign bus.mem_wen_o_prs = wen_q;

`ifdef PRS_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating output-transfer counter; clear beats increment
  always_ff @(posedge clk_i_prs or posedge rst_i_prs) begin : xfer_cnt
    if (rst_i_prs) begin
      cnt_q <= '0;
    end else if (clr_i_prs) begin
      cnt_q <= '0;
    end else if (xfer_out_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o_prs = cnt_q;
`endif

endmodule

// File: tb/tb_pkt_rsel_rr.sv
// tb_pkt_rsel_rr: directed + randomized bench for pkt_rsel_rr against a
// transaction-level reference model (grant by modular search, packet copy).
module tb_pkt_rsel_rr;
  localparam int NCH    = 4;
  localparam int CH_W   = 2;
  localparam int NODE_W = 16;
  localparam int GEN_W  = 12;
  localparam int OPR_W  = 32;
  localparam int WEN_W  = 2;

  logic clk = 1'b0;
  logic rst;

  pkt_rsel_rr_if #(.NCH(NCH), .CH_W(CH_W), .NODE_W(NODE_W), .GEN_W(GEN_W),
                   .OPR_W(OPR_W), .WEN_W(WEN_W)) bus ();

`ifdef PRS_PKT_CNT_EN
  logic        clr;
  logic [15:0] cnt;
`endif

  pkt_rsel_rr #(.NCH(NCH), .CH_W(CH_W), .NODE_W(NODE_W), .GEN_W(GEN_W),
                .OPR_W(OPR_W), .WEN_W(WEN_W)) dut (
    .clk_i_prs (clk),
    .rst_i_prs (rst),
`ifdef PRS_PKT_CNT_EN
    .clr_i_prs (clr),
    .cnt_o_prs (cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int                m_ptr;
  bit                m_valid;
  int                m_ch;
  logic [NODE_W-1:0] m_node;
  logic [GEN_W-1:0]  m_gen;
  logic [OPR_W-1:0]  m_o0;
  logic [OPR_W-1:0]  m_o1;
  logic [WEN_W-1:0]  m_wen;
  int                m_cnt;

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_ch = 0; m_node = '0; m_gen = '0;
    m_o0 = '0; m_o1 = '0; m_wen = '0; m_cnt = 0;
  endtask

  function automatic bit vbit(input int c);
    logic [NCH-1:0] t;
    t = bus.valid_i_prs >> c;
    return t[0];
  endfunction

  // Granted channel from the current inputs, or -1
  function automatic int exp_grant();
    int s;
    if (bus.mode_i_prs) begin
      s = int'(bus.sel_i_prs);
      if (s < NCH && vbit(s)) return s;
      return -1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (vbit((m_ptr + i) % NCH)) return (m_ptr + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0 || !(!m_valid || bus.ready_i_prs)) return '0;
    return NCH'(1) << g;
  endfunction

  task automatic model_update();
    int g;
    bit ld, xo;
    g  = exp_grant();
    ld = !m_valid || bus.ready_i_prs;
    xo = m_valid && bus.ready_i_prs;
`ifdef PRS_PKT_CNT_EN
    if (clr) m_cnt = 0;
    else if (xo && m_cnt < 65535) m_cnt++;
`endif
    if (ld && g >= 0) begin
      m_node  = NODE_W'(bus.node_i_prs >> (g * NODE_W));
      m_gen   = GEN_W'(bus.gen_i_prs >> (g * GEN_W));
      m_o0    = OPR_W'(bus.opr0_i_prs >> (g * OPR_W));
      m_o1    = OPR_W'(bus.opr1_i_prs >> (g * OPR_W));
      m_wen   = WEN_W'(bus.mem_wen_i_prs >> (g * WEN_W));
      m_ch    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NCH;
    end else if (xo) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("valid_o", 64'(bus.valid_o_prs), 64'(m_valid));
    check_val("ch_o", 64'(bus.ch_o_prs), 64'(m_ch));
    check_val("node_o", 64'(bus.node_o_prs), 64'(m_node));
    check_val("gen_o", 64'(bus.gen_o_prs), 64'(m_gen));
    check_val("opr0_o", 64'(bus.opr0_o_prs), 64'(m_o0));
    check_val("opr1_o", 64'(bus.opr1_o_prs), 64'(m_o1));
    check_val("mem_wen_o", 64'(bus.mem_wen_o_prs), 64'(m_wen));
`ifdef PRS_PKT_CNT_EN
    check_val("cnt_o", 64'(cnt), 64'(m_cnt));
`endif
  endtask

  // One clock: check ready against the model, clock, update, check outputs
  task automatic step();
    #1;
    check_val("ready_o", 64'(bus.ready_o_prs), 64'(exp_ready()));
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic set_ch(input int k, input logic [NODE_W-1:0] nd, input logic [GEN_W-1:0] gn,
                        input logic [OPR_W-1:0] a, input logic [OPR_W-1:0] b,
                        input logic [WEN_W-1:0] w);
    bus.node_i_prs[k*NODE_W +: NODE_W]   = nd;
    bus.gen_i_prs[k*GEN_W +: GEN_W]      = gn;
    bus.opr0_i_prs[k*OPR_W +: OPR_W]     = a;
    bus.opr1_i_prs[k*OPR_W +: OPR_W]     = b;
    bus.mem_wen_i_prs[k*WEN_W +: WEN_W]  = w;
  endtask

  task automatic rand_fields();
    for (int k = 0; k < NCH; k++) begin
      set_ch(k, NODE_W'($urandom), GEN_W'($urandom), $urandom, $urandom, WEN_W'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.mode_i_prs  = 1'b0;
    bus.sel_i_prs   = '0;
    bus.ready_i_prs = 1'b1;
    bus.valid_i_prs = '1;
`ifdef PRS_PKT_CNT_EN
    clr = 1'b0;
`endif
    for (int k = 0; k < NCH; k++) begin
      set_ch(k, NODE_W'(16'hA5A0 + k), GEN_W'(k), 32'h1000 + k, 32'h2000 + k, WEN_W'(k));
    end
    model_reset();

    // Reset state: no ready while reset is held, outputs cleared
    #2;
    check_val("rst_ready", 64'(bus.ready_o_prs), 64'(0));
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Round-robin fairness, all valid, full throughput
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("rr_ch", 64'(bus.ch_o_prs), 64'(i % 4));
      check_val("rr_node", 64'(bus.node_o_prs), 64'(16'hA5A0 + (i % 4)));
    end

    // Backpressure with channel 1 holding a distinctive operand
    set_ch(1, 16'hA5A1, 12'h001, 32'hDEADBEEF, 32'h2001, 2'd1);
    step();  // ch0
    step();  // ch1
    check_val("bp_load_ch", 64'(bus.ch_o_prs), 64'(1));
    bus.ready_i_prs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_ready", 64'(bus.ready_o_prs), 64'(0));
      check_val("bp_opr0", 64'(bus.opr0_o_prs), 64'(32'hDEADBEEF));
      check_val("bp_ch", 64'(bus.ch_o_prs), 64'(1));
    end
    bus.ready_i_prs = 1'b1;
    step();
    check_val("bp_release_ch", 64'(bus.ch_o_prs), 64'(2));
    check_val("bp_release_valid", 64'(bus.valid_o_prs), 64'(1));

    // Forced mode: selected channel not valid -> no grant, no fallback
    bus.mode_i_prs  = 1'b1;
    bus.sel_i_prs   = 2'd2;
    bus.valid_i_prs = 4'b1011;
    step();
    step();
    check_val("forced_idle_valid", 64'(bus.valid_o_prs), 64'(0));
    bus.valid_i_prs = 4'b1111;
    set_ch(2, 16'hA5A2, 12'h3C5, 32'h1002, 32'h2002, 2'd2);
    #1;
    check_val("forced_ready", 64'(bus.ready_o_prs), 64'(4'b0100));
    step();
    check_val("forced_gen", 64'(bus.gen_o_prs), 64'(12'h3C5));
    check_val("forced_ch", 64'(bus.ch_o_prs), 64'(2));

    // Pointer continuity after a forced grant, then wrap
    bus.mode_i_prs = 1'b0;
    step();
    check_val("cont_ch3", 64'(bus.ch_o_prs), 64'(3));
    step();
    check_val("wrap_ch0", 64'(bus.ch_o_prs), 64'(0));

    // Asynchronous reset while a packet is held
    bus.ready_i_prs = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(bus.valid_o_prs), 64'(0));
    check_val("arst_node", 64'(bus.node_o_prs), 64'(16'h0000));
    check_val("arst_ch", 64'(bus.ch_o_prs), 64'(0));
    check_val("arst_ready", 64'(bus.ready_o_prs), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ready_i_prs = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      bus.valid_i_prs = NCH'($urandom);
      bus.mode_i_prs  = ($urandom_range(0, 3) == 0);
      bus.sel_i_prs   = CH_W'($urandom);
      bus.ready_i_prs = ($urandom_range(0, 3) != 0);
`ifdef PRS_PKT_CNT_EN
      clr = ($urandom_range(0, 63) == 0);
`endif
      step();
    end

`ifdef PRS_PKT_CNT_EN
    // Counter: clear beats a same-cycle transfer, then count, then saturate
    clr = 1'b0;
    bus.mode_i_prs  = 1'b0;
    bus.valid_i_prs = '1;
    bus.ready_i_prs = 1'b1;
    step();
    step();
    clr = 1'b1;
    step();
    check_val("cnt_clr", 64'(cnt), 64'(0));
    clr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_val("cnt_five", 64'(cnt), 64'(5));
    for (int i = 0; i < 65540; i++) step();
    check_val("cnt_sat", 64'(cnt), 64'(16'hFFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_rsel_rr.md
Name: pkt_rsel_rr

Overview:
- Registered N-channel result-packet selector. Successor to the two-input combinational packet select.
- Arbitrates NCH packet sources (node, gen, opr0, opr1, mem_wen fields) onto one output stage with valid/ready handshakes.
- Two selection modes: round-robin, or forced channel select (generalises the old a/b select line).
- Sits between the operand-matching units and the memory/node write-back path.

Parameters:
NCH, 4, number of input channels (2..16)
CH_W, 2, channel index width; must equal clog2(NCH), minimum 1
NODE_W, 16, node field width
GEN_W, 12, generation field width
OPR_W, 32, width of each operand field
WEN_W, 2, memory write-enable field width

Ports:
clk_i_prs  in  1  clock
rst_i_prs  in  1  asynchronous active-high reset
node_i_prs  in  NCH*NODE_W  packed node fields; channel k occupies [k*NODE_W +: NODE_W]
gen_i_prs  in  NCH*GEN_W  packed gen fields
opr0_i_prs  in  NCH*OPR_W  packed operand 0 fields
opr1_i_prs  in  NCH*OPR_W  packed operand 1 fields
mem_wen_i_prs  in  NCH*WEN_W  packed write-enable fields
valid_i_prs  in  NCH  per-channel packet valid
ready_o_prs  out  NCH  per-channel accept; at most one bit high per cycle
mode_i_prs  in  1  0 = round-robin, 1 = forced select
sel_i_prs  in  CH_W  forced channel index (used when mode_i_prs=1)
node_o_prs  out  NODE_W  selected node
gen_o_prs  out  GEN_W  selected gen
opr0_o_prs  out  OPR_W  selected operand 0
opr1_o_prs  out  OPR_W  selected operand 1
mem_wen_o_prs  out  WEN_W  selected write-enable
ch_o_prs  out  CH_W  source channel of the held packet
valid_o_prs  out  1  output packet valid
ready_i_prs  in  1  downstream accept

Behaviour:
- Reset (async, active-high): valid_o_prs=0; all data outputs=0; ch_o_prs=0; round-robin pointer=0. ready_o_prs stays 0 while reset is asserted.
- Output stage is a single register. load = !valid_o_prs | ready_i_prs.
- Output transfer occurs when valid_o_prs & ready_i_prs.
- Grant is combinational, computed each cycle:
  - Round-robin: first channel with valid set, searching from ptr upward with wrap (ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1).
  - Forced: grants channel sel_i_prs only if its valid bit is set. Otherwise no grant. No fallback to other channels.
  - sel_i_prs >= NCH: no grant.
- ready_o_prs[k] = load & grant[k]. Input transfer on channel k = valid_i_prs[k] & ready_o_prs[k].
- On an input transfer:
  - The packet fields and the channel index are registered.
  - valid_o_prs=1 on the next cycle (latency 1).
  - ptr <= granted+1, wrapping to 0 at NCH.
- Forced-mode grants also advance ptr, so round-robin fairness resumes from the last served channel.
- Transfer out with no new input: valid_o_prs <= 0; data outputs hold their last value.
- Simultaneous transfer out and transfer in: the register is replaced in the same cycle; valid_o_prs stays 1. Full throughput of one packet per cycle.
- Downstream stall (valid_o_prs=1, ready_i_prs=0): outputs held stable; all ready_o_prs=0; ptr frozen.
- Packets are never dropped or duplicated. Input fields are sampled only on the transfer cycle.
- Mode switch is effective in the same cycle; no state flush.
- Reset mid-transfer: the held packet is discarded. Sources must treat reset as aborting outstanding handshakes.

Optional Feature:
- Macro: PRS_PKT_CNT_EN.
- Defined:
  - Adds output port cnt_o_prs [15:0], a count of output transfers.
  - Increments on each valid_o_prs & ready_i_prs and saturates at 16'hFFFF.
  - Also adds input clr_i_prs. It synchronously zeroes the counter and has priority over increment.
  - Reset value is 0.
- Undefined: neither port exists; no counter logic is built.

Test Plan:
- Reset: assert rst_i_prs mid-stream with valid_o_prs=1 -> valid_o_prs=0, node_o_prs=16'h0000, ch_o_prs=0 immediately (asynchronous).
- Round-robin fairness (NCH=4): all valid held high, ready_i_prs=1 -> ch_o_prs sequence 0,1,2,3,0,... one packet per cycle; node_o_prs equals the packed node of the granted channel (e.g. ch2 node 16'hA5A2).
- Backpressure: ready_i_prs=0 for 3 cycles while channel 1 holds opr0=32'hDEADBEEF -> outputs constant, ready_o_prs=4'b0000. On release, the next packet loads in the same cycle.
- Forced mode: mode=1, sel=2, valid=4'b1011 -> no grant, valid_o_prs stays 0. Then set valid[2]=1 with gen=12'h3C5 -> ready_o_prs=4'b0100; next cycle gen_o_prs=12'h3C5, ch_o_prs=2.
- Pointer continuity: forced grant on ch 2, then mode=0 with all valid -> next grant is ch 3. Wrap case: after ch 3 the next grant is ch 0.
- PRS_PKT_CNT_EN: 5 output transfers -> cnt_o_prs=5. clr_i_prs asserted in a cycle that also has a transfer -> 0. Preload near the limit -> holds at 16'hFFFF.
